symbol_deserializer_fifo: RTL
=============================

Name: symbol_deserializer_fifo

Overview:
- Parametrised successor of the 2-bit symbol deserializer in the Z-Modem receive path.
- Packs SYM_W-bit demodulated symbols into BLOCK_W-bit cipher blocks for the decryption engine.
- Adds input back-pressure, a configurable symbol order, frame resynchronisation and an OUT_DEPTH-entry output block FIFO, so symbol intake continues while the decryptor stalls.

Parameters:
- SYM_W, 2: bits per symbol; must divide BLOCK_W, checked at elaboration.
- BLOCK_W, 128: cipher block width.
- OUT_DEPTH, 2: number of output FIFO entries; minimum 1, power of two.
- MSB_FIRST, 1: 1 = first symbol lands at [BLOCK_W-1 -: SYM_W]; 0 = first symbol lands at [SYM_W-1:0].

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- symbol_in  in  SYM_W  demodulated symbol.
- symbol_valid  in  1  symbol_in is valid this cycle.
- symbol_ready  out  1  block accepts a symbol this cycle.
- frame_sync  in  1  discards any partial block; the next accepted symbol is symbol 0.
- cipher_block  out  BLOCK_W  FIFO head block.
- block_valid  out  1  FIFO is not empty.
- dec_ready  in  1  decryptor accepts cipher_block.
- sym_count  out  clog2(BLOCK_W/SYM_W)  symbols held in the partial block.
- fifo_level  out  clog2(OUT_DEPTH+1)  number of queued blocks.
- sync_drop  out  1  one-cycle pulse when frame_sync discards a non-empty partial block.

Behaviour:
- SYMS = BLOCK_W/SYM_W. A symbol is accepted when symbol_valid && symbol_ready.
- Reset values: symbol_ready=1, block_valid=0, cipher_block=0, sym_count=0, fifo_level=0, sync_drop=0. The assembly register clears. Reset mid-block discards both the partial block and the FIFO contents; sync_drop is not raised.
- Ready rule: symbol_ready = (sym_count != SYMS-1) || (fifo_level != OUT_DEPTH). It depends on registered state only, with no combinational path from dec_ready.
- Assembly, MSB_FIRST=1: shift_reg <= {shift_reg[BLOCK_W-SYM_W-1:0], symbol_in}.
- Assembly, MSB_FIRST=0: shift_reg <= {symbol_in, shift_reg[BLOCK_W-1:SYM_W]}.
- sym_count increments per accepted symbol.
- On acceptance at sym_count==SYMS-1, the completed block (including that symbol) is written straight into the FIFO and sym_count wraps to 0.
- Latency: block_valid rises on the cycle after the last symbol is accepted, when the FIFO was empty.
- Output handshake:
  - A pop occurs on block_valid && dec_ready.
  - cipher_block and block_valid hold stable while dec_ready=0.
  - Blocks leave in arrival order.
- Simultaneous push and pop: fifo_level is unchanged; both take effect. Because of the ready rule, a push never occurs when the FIFO is full.
- frame_sync:
  - In that cycle, sym_count <= 0 and the partial block is dropped.
  - sync_drop pulses on the next cycle if sym_count != 0.
  - If symbol_valid is high in the same cycle, that symbol is accepted as symbol 0 of the new block and sym_count becomes 1.
  - FIFO contents are unaffected.
- A pop during frame_sync proceeds normally.
- Widths: all counters are sized exactly. The FIFO pointers wrap modulo OUT_DEPTH.

Decomposition:
- Package zm_deser_pkg holds:
  - the SYMS and count-width helper functions, clog2-based;
  - default constants ZM_SYM_W=2 and ZM_BLOCK_W=128;
  - the MSB_FIRST encoding.
- Sub-module zm_block_fifo: synchronous FIFO parametrised by width and depth. Ports: push/pop, full/empty, level. Head data is registered (first-word-fall-through).
- The top level holds the assembly register, the symbol counter and the sync logic.

Test Plan:
1. MSB_FIRST=1, dec_ready=1. Send 128'h0123456789ABCDEF0123456789ABCDEF, 2 MSBs per symbol, 64 symbols. -> block_valid=1 for exactly one cycle, one cycle after symbol 64, with cipher_block equal to that value.
2. dec_ready=0. Send 128'hFEDCBA9876543210FEDCBA9876543210, then 128'h0123456789ABCDEF0123456789ABCDEF, then 63 symbols of a third block.
   - fifo_level=2 and symbol_ready=0 at sym_count=63; the held symbol is not lost.
   - Raise dec_ready: the FE.. block pops, then the 01.. block, then the third block completes.
3. frame_sync after 10 symbols. -> sync_drop pulses once and sym_count=0; the next 64 symbols yield the correct block with no stale bits. A frame_sync at sym_count=0 gives no sync_drop.
4. Repeating symbols 0,1,2,3 for 64 symbols. -> MSB_FIRST=1 gives 128'h1B1B..1B; MSB_FIRST=0 gives 128'hE4E4..E4.
5. Reset after 30 symbols with one block queued. -> block_valid=0, fifo_level=0, sym_count=0, no sync_drop. The next 64 symbols form a clean block.
6. SYM_W=4, BLOCK_W=32, OUT_DEPTH=1. Send nibbles 1..8 twice with dec_ready=0. -> first block 32'h12345678; symbol_ready drops at the 8th nibble of the second block and recovers after a pop.

Source files
------------

// File: rtl/zm_deser_pkg.sv
// Shared constants and sizing helpers for the Z-Modem symbol deserializer.
package zm_deser_pkg;

    localparam int unsigned ZM_SYM_W   = 2;
    localparam int unsigned ZM_BLOCK_W = 128;

    // Where the first symbol of a block lands.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } sym_order_e;

    // Number of symbols that make up one cipher block.
    function automatic int unsigned syms_per_block(input int unsigned block_w,
                                                   input int unsigned sym_w);
        return block_w / sym_w;
    endfunction

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/symbol_deserializer_fifo_if.sv
// Symbol intake and cipher-block output bundle of the deserializer.
interface symbol_deserializer_fifo_if
    import zm_deser_pkg::*;
#(
    parameter int unsigned SYM_W     = ZM_SYM_W,
    parameter int unsigned BLOCK_W   = ZM_BLOCK_W,
    parameter int unsigned OUT_DEPTH = 2
) ();

    localparam int unsigned SYMS  = syms_per_block(BLOCK_W, SYM_W);
    localparam int unsigned CNT_W = cnt_w(SYMS);
    localparam int unsigned LVL_W = cnt_w(OUT_DEPTH + 1);

    logic [SYM_W-1:0]   symbol_in;
    logic               symbol_valid;
    logic               symbol_ready;
    logic               frame_sync;
    logic [BLOCK_W-1:0] cipher_block;
    logic               block_valid;
    logic               dec_ready;
    logic [CNT_W-1:0]   sym_count;
    logic [LVL_W-1:0]   fifo_level;
    logic               sync_drop;

    // Deserializer side.
    modport slave (
        input  symbol_in, symbol_valid, frame_sync, dec_ready,
        output symbol_ready, cipher_block, block_valid, sym_count, fifo_level, sync_drop
    );

    // Demodulator / decryptor side.
    modport master (
        output symbol_in, symbol_valid, frame_sync, dec_ready,
        input  symbol_ready, cipher_block, block_valid, sym_count, fifo_level, sync_drop
    );

endinterface

// File: rtl/zm_block_fifo.sv
// Synchronous block FIFO with a registered head word (first-word-fall-through).
module zm_block_fifo
    import zm_deser_pkg::*;
#(
    parameter int unsigned WIDTH = ZM_BLOCK_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head_data,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_w(DEPTH + 1)-1:0]   level
);

    localparam int unsigned PTR_W = cnt_w(DEPTH);
    localparam int unsigned LVL_W = cnt_w(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [LVL_W-1:0] level_next;
    logic [WIDTH-1:0] head_next;
    logic             wr_en, rd_en;

    // Pointers wrap at DEPTH-1, so non-power-of-two depths stay correct too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointers, level and head word.
    always_comb begin
        wr_en       = push && !full;
        rd_en       = pop && !empty;
        wr_ptr_next = wr_en ? next_ptr(wr_ptr) : wr_ptr;
        rd_ptr_next = rd_en ? next_ptr(rd_ptr) : rd_ptr;
        level_next  = level;
        head_next   = head_data;
        if (wr_en && !rd_en) begin
            level_next = level + LVL_W'(1);
        end else if (!wr_en && rd_en) begin
            level_next = level - LVL_W'(1);
        end
        // Incoming word becomes the head when it is (or is about to be) the only entry.
        if (wr_en && (empty || (rd_en && level == LVL_W'(1)))) begin
            head_next = push_data;
        end else if (rd_en && level > LVL_W'(1)) begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            head_data <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            level     <= level_next;
            head_data <= head_next;
            empty     <= (level_next == '0);
            full      <= (level_next == LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/symbol_deserializer_fifo.sv
// Packs demodulated symbols into cipher blocks and queues them for the decryptor.
module symbol_deserializer_fifo
    import zm_deser_pkg::*;
#(
    parameter int unsigned SYM_W     = ZM_SYM_W,
    parameter int unsigned BLOCK_W   = ZM_BLOCK_W,
    parameter int unsigned OUT_DEPTH = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                        clk,
    input logic                        reset,
    symbol_deserializer_fifo_if.slave  bus
);

    localparam int unsigned SYMS      = syms_per_block(BLOCK_W, SYM_W);
    localparam int unsigned CNT_W     = cnt_w(SYMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMS - 1);
    localparam bit          MSB_ORDER = (sym_order_e'(MSB_FIRST) == ORDER_MSB_FIRST);

    if ((BLOCK_W % SYM_W) != 0 || SYMS < 2) begin : g_bad_width
        $error("BLOCK_W must be a multiple of SYM_W holding at least two symbols");
    end
    if (OUT_DEPTH < 1 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("OUT_DEPTH must be a power of two, at least 1");
    end

    logic [BLOCK_W-1:0] shift_reg, shift_base, shift_next;
    logic [CNT_W-1:0]   count_q, count_base, count_next;
    logic               drop_q, drop_next;
    logic               ready, accept, push, pop;
    logic               fifo_full, fifo_empty;

    // Only registered state decides readiness: stall only when the last symbol has nowhere to go.
    assign ready  = (count_q != LAST) || !fifo_full;
    assign accept = bus.symbol_valid && ready;
    assign pop    = !fifo_empty && bus.dec_ready;

    // Assembly, symbol count and resync.
    always_comb begin
        shift_base = shift_reg;
        count_base = count_q;
        drop_next  = 1'b0;
        push       = 1'b0;
        if (bus.frame_sync) begin
            shift_base = '0;
            count_base = '0;
            drop_next  = (count_q != '0);
        end
        shift_next = shift_base;
        count_next = count_base;
        if (accept) begin
            if (MSB_ORDER) begin
                shift_next = {shift_base[BLOCK_W-SYM_W-1:0], bus.symbol_in};
            end else begin
                shift_next = {bus.symbol_in, shift_base[BLOCK_W-1:SYM_W]};
            end
            if (count_base == LAST) begin
                push       = 1'b1;
                count_next = '0;
            end else begin
                count_next = count_base + CNT_W'(1);
            end
        end
    end

    // Assembly register, counter and drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            count_q   <= count_next;
            drop_q    <= drop_next;
        end
    end

    // Completed blocks go straight into the output queue.
    zm_block_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_next),
        .pop       (pop),
        .head_data (bus.cipher_block),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (bus.fifo_level)
    );

    assign bus.symbol_ready = ready;
    assign bus.block_valid  = !fifo_empty;
    assign bus.sym_count    = count_q;
    assign bus.sync_drop    = drop_q;

endmodule
